// File: rtl/accum_bus_pkg.sv
// Shared encodings for the accumulator bus controller: source-select codes and FSM states.
package accum_bus_pkg;

    localparam logic [1:0] SRC_DATA = 2'b00;
    localparam logic [1:0] SRC_ALU  = 2'b01;
    localparam logic [1:0] SRC_COPY = 2'b10;
    localparam logic [1:0] SRC_SWAP = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } state_t;

endpackage

// File: rtl/accum_bus_bank.sv
// NUM_ACC x DATA_W accumulator array: one write port, two read ports, synchronous clear.
module accum_bus_bank #(
    parameter int DATA_W  = 4,
    parameter int NUM_ACC = 2,
    parameter int SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic                             CLK,
    input  logic                             clr,
    input  logic                             we,
    input  logic [SEL_W-1:0]                 waddr,
    input  logic [DATA_W-1:0]                wdata,
    input  logic [SEL_W-1:0]                 raddr_a,
    input  logic [SEL_W-1:0]                 raddr_b,
    output logic [DATA_W-1:0]                rdata_a,
    output logic [DATA_W-1:0]                rdata_b,
    output logic [NUM_ACC-1:0][DATA_W-1:0]   acc
);

    genvar i;
    generate
        for (i = 0; i < NUM_ACC; i++) begin : g_acc
            always_ff @(posedge CLK) begin
                if (clr)
                    acc[i] <= '0;
                else if (we && waddr == SEL_W'(i))
                    acc[i] <= wdata;
            end
        end
    endgenerate

    // Out-of-range read indices return zero; callers reject such requests anyway.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int k = 0; k < NUM_ACC; k++) begin
            if (raddr_a == SEL_W'(k)) rdata_a = acc[k];
            if (raddr_b == SEL_W'(k)) rdata_b = acc[k];
        end
    end

endmodule

// File: rtl/accum_bus_ctrl.sv
// Accumulator bank bus controller: load/copy/swap with busy/done handshake and sticky error.
// Optional ZERO_FLAGS output enabled by defining ACC_BUS_ZERO_FLAG_EN.
module accum_bus_ctrl
    import accum_bus_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int NUM_ACC = 2,
    parameter int SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      LOAD_EN,
    input  logic [SEL_W-1:0]          LOAD_SEL,
    input  logic [1:0]                SRC_SEL,
    input  logic [SEL_W-1:0]          COPY_SEL,
    input  logic [DATA_W-1:0]         DATA,
    input  logic [DATA_W-1:0]         ALUOUT,
    input  logic                      ERR_CLR,
    output logic [NUM_ACC*DATA_W-1:0] ACC_FLAT,
    output logic [DATA_W-1:0]         BUS,
    output logic                      BUSY,
    output logic                      LOAD_DONE,
    output logic                      BUS_ERR
`ifdef ACC_BUS_ZERO_FLAG_EN
    ,
    output logic [NUM_ACC-1:0]        ZERO_FLAGS
`endif
);

    localparam logic [SEL_W:0] NUM_ACC_V = NUM_ACC[SEL_W:0];

    state_t                          state, state_nxt;
    logic [DATA_W-1:0]               tmp;
    logic [SEL_W-1:0]                copy_lat;
    logic [NUM_ACC-1:0][DATA_W-1:0]  acc;
    logic [DATA_W-1:0]               rd_a, rd_b;
    logic                            we, bus_we, done_nxt, err_set, swap_start;
    logic [SEL_W-1:0]                waddr;
    logic [DATA_W-1:0]               wdata;
    logic                            req_ok;

    // Copy/swap also need a legal source index.
    assign req_ok = ({1'b0, LOAD_SEL} < NUM_ACC_V) &&
                    (!SRC_SEL[1] || ({1'b0, COPY_SEL} < NUM_ACC_V));

    accum_bus_bank #(.DATA_W(DATA_W), .NUM_ACC(NUM_ACC), .SEL_W(SEL_W)) u_bank (
        .CLK     (CLK),
        .clr     (RST),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (LOAD_SEL),
        .raddr_b (COPY_SEL),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .acc     (acc)
    );

    always_comb begin
        state_nxt  = state;
        we         = 1'b0;
        bus_we     = 1'b0;
        waddr      = LOAD_SEL;
        wdata      = DATA;
        done_nxt   = 1'b0;
        err_set    = 1'b0;
        swap_start = 1'b0;
        case (state)
            IDLE: begin
                if (LOAD_EN) begin
                    if (!req_ok) begin
                        err_set = 1'b1;
                    end else begin
                        we = 1'b1;
                        case (SRC_SEL)
                            SRC_DATA: wdata = DATA;
                            SRC_ALU:  wdata = ALUOUT;
                            default:  wdata = rd_b;
                        endcase
                        if (SRC_SEL == SRC_SWAP) begin
                            swap_start = 1'b1;
                            state_nxt  = SWAP2;
                        end else begin
                            bus_we   = 1'b1;
                            done_nxt = 1'b1;
                        end
                    end
                end
            end
            SWAP2: begin
                we        = 1'b1;
                waddr     = copy_lat;
                wdata     = tmp;
                bus_we    = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
                err_set   = LOAD_EN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tmp       <= '0;
            copy_lat  <= '0;
            BUS       <= '0;
            LOAD_DONE <= 1'b0;
            BUS_ERR   <= 1'b0;
        end else begin
            state     <= state_nxt;
            LOAD_DONE <= done_nxt;
            if (swap_start) begin
                tmp      <= rd_a;
                copy_lat <= COPY_SEL;
            end
            if (bus_we)
                BUS <= wdata;
            // A new error outranks a same-edge clear.
            if (err_set)
                BUS_ERR <= 1'b1;
            else if (ERR_CLR)
                BUS_ERR <= 1'b0;
        end
    end

    assign BUSY     = (state == SWAP2);
    assign ACC_FLAT = acc;

`ifdef ACC_BUS_ZERO_FLAG_EN
    genvar z;
    generate
        for (z = 0; z < NUM_ACC; z++) begin : g_zf
            assign ZERO_FLAGS[z] = (acc[z] == '0);
        end
    endgenerate
`endif

endmodule

// File: tb/tb_accum_bus_ctrl.sv
// Directed self-checking bench for accum_bus_ctrl (DATA_W=4, NUM_ACC=3).
module tb_accum_bus_ctrl;

    localparam int DW = 4;
    localparam int NA = 3;
    localparam int SW = 2;

    logic          CLK = 1'b0;
    logic          RST, LOAD_EN, ERR_CLR;
    logic [SW-1:0] LOAD_SEL, COPY_SEL;
    logic [1:0]    SRC_SEL;
    logic [DW-1:0] DATA, ALUOUT;
    logic [NA*DW-1:0] ACC_FLAT;
    logic [DW-1:0] BUS;
    logic          BUSY, LOAD_DONE, BUS_ERR;
`ifdef ACC_BUS_ZERO_FLAG_EN
    logic [NA-1:0] ZERO_FLAGS;
`endif

    int tests = 0;
    int fails = 0;

    accum_bus_ctrl #(.DATA_W(DW), .NUM_ACC(NA)) dut (
        .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .LOAD_SEL(LOAD_SEL),
        .SRC_SEL(SRC_SEL), .COPY_SEL(COPY_SEL), .DATA(DATA), .ALUOUT(ALUOUT),
        .ERR_CLR(ERR_CLR), .ACC_FLAT(ACC_FLAT), .BUS(BUS), .BUSY(BUSY),
        .LOAD_DONE(LOAD_DONE), .BUS_ERR(BUS_ERR)
`ifdef ACC_BUS_ZERO_FLAG_EN
        , .ZERO_FLAGS(ZERO_FLAGS)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] src, input logic [SW-1:0] ld, input logic [SW-1:0] cp,
                       input logic [DW-1:0] d);
        LOAD_EN = 1'b1; SRC_SEL = src; LOAD_SEL = ld; COPY_SEL = cp; DATA = d;
        step();
        LOAD_EN = 1'b0;
    endtask

    initial begin
        RST = 1'b1; LOAD_EN = 1'b0; ERR_CLR = 1'b0; LOAD_SEL = '0; COPY_SEL = '0;
        SRC_SEL = '0; DATA = '0; ALUOUT = '0;
        step(); step();
        RST = 1'b0;
        chk("rst_acc",  ACC_FLAT, 12'h000);
        chk("rst_bus",  BUS, 4'h0);
        chk("rst_ctl",  {BUSY, LOAD_DONE, BUS_ERR}, 3'b000);
`ifdef ACC_BUS_ZERO_FLAG_EN
        chk("rst_zf",   ZERO_FLAGS, 3'b111);
`endif

        // immediate load
        req(2'b00, 2'd0, 2'd0, 4'hA);
        chk("ld_acc",   ACC_FLAT, 12'h00A);
        chk("ld_bus",   BUS, 4'hA);
        chk("ld_done",  LOAD_DONE, 1'b1);
        step();
        chk("ld_done1", LOAD_DONE, 1'b0);

        // ALU load then copy
        ALUOUT = 4'h5;
        req(2'b01, 2'd1, 2'd0, 4'h0);
        chk("alu_acc",  ACC_FLAT, 12'h05A);
        chk("alu_done", LOAD_DONE, 1'b1);
        req(2'b10, 2'd0, 2'd1, 4'h0);
        chk("cp_acc",   ACC_FLAT, 12'h055);
        chk("cp_done",  LOAD_DONE, 1'b1);
        chk("cp_bus",   BUS, 4'h5);
        req(2'b10, 2'd1, 2'd1, 4'h0);
        chk("cp_self",  ACC_FLAT, 12'h055);

        // swap 0<->1 from ACC0=3, ACC1=C
        req(2'b00, 2'd0, 2'd0, 4'h3);
        req(2'b00, 2'd1, 2'd0, 4'hC);
        chk("pre_sw",   ACC_FLAT, 12'h0C3);
        req(2'b11, 2'd0, 2'd1, 4'h0);
        chk("sw1_ctl",  {BUSY, LOAD_DONE}, 2'b10);
        chk("sw1_acc",  ACC_FLAT, 12'h0CC);
        chk("sw1_bus",  BUS, 4'hC);
        step();
        chk("sw2_ctl",  {BUSY, LOAD_DONE}, 2'b01);
        chk("sw2_acc",  ACC_FLAT, 12'h03C);
        chk("sw2_bus",  BUS, 4'h3);
        step();
        chk("sw3_done", LOAD_DONE, 1'b0);

        // request during BUSY is dropped and flagged
        req(2'b11, 2'd0, 2'd1, 4'h0);
        req(2'b00, 2'd2, 2'd0, 4'hF);
        chk("bz_acc",   ACC_FLAT, 12'h0C3);
        chk("bz_bus",   BUS, 4'hC);
        chk("bz_ctl",   {BUSY, LOAD_DONE, BUS_ERR}, 3'b011);
        step(); step();
        chk("bz_hold",  BUS_ERR, 1'b1);
        ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
        chk("bz_clr",   BUS_ERR, 1'b0);

        // out-of-range indices
        req(2'b00, 2'd3, 2'd0, 4'h7);
        chk("oor_acc",  ACC_FLAT, 12'h0C3);
        chk("oor_ctl",  {LOAD_DONE, BUS_ERR}, 2'b01);
        ERR_CLR = 1'b1;
        req(2'b10, 2'd0, 2'd3, 4'h0);
        ERR_CLR = 1'b0;
        chk("oor_set",  BUS_ERR, 1'b1);
        chk("oor_acc2", ACC_FLAT, 12'h0C3);
        ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
        chk("oor_clr",  BUS_ERR, 1'b0);

        // equal-index swap takes two cycles, no change
        req(2'b00, 2'd2, 2'd0, 4'h9);
        req(2'b11, 2'd2, 2'd2, 4'h0);
        chk("eq_busy",  {BUSY, LOAD_DONE}, 2'b10);
        step();
        chk("eq_done",  {BUSY, LOAD_DONE}, 2'b01);
        chk("eq_acc",   ACC_FLAT, 12'h9C3);
        chk("eq_bus",   BUS, 4'h9);
`ifdef ACC_BUS_ZERO_FLAG_EN
        chk("eq_zf",    ZERO_FLAGS, 3'b000);
`endif

        // reset in SWAP2 abandons the swap
        req(2'b11, 2'd0, 2'd1, 4'h0);
        chk("rs_busy",  BUSY, 1'b1);
        RST = 1'b1; step(); RST = 1'b0;
        chk("rs_acc",   ACC_FLAT, 12'h000);
        chk("rs_ctl",   {BUSY, LOAD_DONE, BUS_ERR}, 3'b000);
        chk("rs_bus",   BUS, 4'h0);
`ifdef ACC_BUS_ZERO_FLAG_EN
        chk("rs_zf",    ZERO_FLAGS, 3'b111);
`endif
        step();
        chk("rs_idle",  {BUSY, LOAD_DONE}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
